// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, responder FSM states and the access legality check.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // A request is legal when its funct3 exists for its direction (no
    // unsigned stores) and its byte offset is naturally aligned.
    function automatic logic legal_access(input logic write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = (off[0] == 1'b0);
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !write;
            F3_HU:   ok = !write && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised backing store with per-byte write enables and a registered
// read port. Contents are never reset.
module dmem_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [3:0]           wr_be,
    input  logic [ADDR_BITS-1:0] wr_idx,
    input  logic [31:0]          wr_data,
    input  logic [ADDR_BITS-1:0] rd_idx,
    output logic [31:0]          rd_data
);

    logic [31:0] mem_r [0:(2**ADDR_BITS)-1];

    // Byte-lane write: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Registered read of the currently addressed word.
    always_ff @(posedge clk) begin
        rd_data <= mem_r[rd_idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one load/store at a time over
// valid/ready, fixed latency from acceptance to response, RV32I lane handling.
module dmem_responder #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    import mem_pkg::*;

    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    state_t                 state_r;
    state_t                 state_s;
    logic [3:0]             cnt_r;
    logic                   write_r;
    logic [2:0]             funct3_r;
    logic [ADDR_BITS-1:0]   idx_r;
    logic [1:0]             off_r;
    logic [WIDTH-1:0]       wdata_r;
    logic                   req_ready_r;
    logic                   rsp_valid_r;
    logic [WIDTH-1:0]       rsp_rdata_r;
    logic                   rsp_err_r;

    logic                   accept_s;
    logic                   done_s;
    logic                   rsp_hs_s;
    logic                   legal_s;
    logic [ADDR_BITS-1:0]   rd_idx_s;
    logic [WIDTH-1:0]       rd_data_s;
    logic [WIDTH-1:0]       shifted_s;
    logic [WIDTH-1:0]       load_s;
    logic [3:0]             be_s;
    logic [WIDTH-1:0]       wlane_s;
    logic [3:0]             wr_be_s;
    logic                   unused_addr_s;

    // Address bits above the array size alias and are deliberately ignored.
    assign unused_addr_s = ^req_addr[WIDTH-1:ADDR_BITS+2];

    assign accept_s = req_valid && req_ready_r;
    assign done_s   = (state_r == BUSY) && (cnt_r == LAT_LAST);
    assign rsp_hs_s = (state_r == RESP) && rsp_valid_r && rsp_ready;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Next-state logic for the IDLE -> BUSY -> RESP handshake sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = BUSY;
                else          state_s = IDLE;
            end
            BUSY: begin
                if (done_s) state_s = RESP;
                else        state_s = BUSY;
            end
            RESP: begin
                if (rsp_hs_s) state_s = IDLE;
                else          state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Lane alignment, extension and byte enables for the latched request.
    always_comb begin
        legal_s   = legal_access(write_r, funct3_r, off_r);
        shifted_s = rd_data_s >> {off_r, 3'b000};
        load_s    = {WIDTH{1'b0}};
        be_s      = 4'b0000;
        wlane_s   = wdata_r;
        case (funct3_r)
            F3_B: begin
                load_s  = {{(WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
                be_s    = 4'b0001 << off_r;
                wlane_s = {4{wdata_r[7:0]}};
            end
            F3_H: begin
                load_s  = {{(WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
                be_s    = 4'b0011 << off_r;
                wlane_s = {2{wdata_r[15:0]}};
            end
            F3_W: begin
                load_s  = rd_data_s;
                be_s    = 4'b1111;
                wlane_s = wdata_r;
            end
            F3_BU: begin
                load_s = {{(WIDTH-8){1'b0}}, shifted_s[7:0]};
            end
            F3_HU: begin
                load_s = {{(WIDTH-16){1'b0}}, shifted_s[15:0]};
            end
            default: begin
                load_s = {WIDTH{1'b0}};
            end
        endcase
        // Commit only a legal store on the BUSY->RESP edge, never under reset.
        if (done_s && write_r && legal_s && rst) wr_be_s = be_s;
        else                                      wr_be_s = 4'b0000;
        // The read port tracks the incoming address while idle so the word is
        // already registered by the first BUSY cycle, even for LATENCY=1.
        if (state_r == IDLE) rd_idx_s = req_addr[ADDR_BITS+1:2];
        else                 rd_idx_s = idx_r;
    end

    // Request latch, latency counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            funct3_r    <= 3'b000;
            idx_r       <= {ADDR_BITS{1'b0}};
            off_r       <= 2'b00;
            wdata_r     <= {WIDTH{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                write_r     <= req_write;
                funct3_r    <= req_funct3;
                idx_r       <= req_addr[ADDR_BITS+1:2];
                off_r       <= req_addr[1:0];
                wdata_r     <= req_wdata;
                cnt_r       <= 4'd0;
                req_ready_r <= 1'b0;
            end
            if ((state_r == BUSY) && !done_s) begin
                cnt_r <= cnt_r + 4'd1;
            end
            if (done_s) begin
                cnt_r       <= 4'd0;
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= !legal_s;
                rsp_rdata_r <= (!legal_s || write_r) ? {WIDTH{1'b0}} : load_s;
            end
            if (rsp_hs_s) begin
                rsp_valid_r <= 1'b0;
                req_ready_r <= 1'b1;
            end
        end
    end

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .wr_be   (wr_be_s),
        .wr_idx  (idx_r),
        .wr_data (wlane_s),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

endmodule
